in_spk_loader: RTL and testbench
================================

Name: in_spk_loader

Overview:
Host-side writer for the input-spike SRAM that the accelerator reads as 128-bit lines through in_spk_read_sram, addressed 0..511. The block accepts a stream of 16-bit spike words over a valid/ready handshake and packs eight words into each line. It writes the lines to consecutive SRAM addresses starting at 0, then reports completion and any framing error to the host sequencer before the accelerator run is started.

Parameters:
WORD_W, 16, width of one incoming spike word
WORDS_PER_LINE, 8, words packed per SRAM line (LINE_W = 128)
ADDR_W, 9, SRAM address width (512 lines)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a load; ignored unless idle
cfg_num_lines  in  10  lines to load; legal range 1..512, latched on start
s_data  in  16  spike word
s_valid  in  1  s_data valid
s_last  in  1  marks the final word of the host frame
s_ready  out  1  block accepts a word this cycle
in_spk_write_sram  out  128  packed line
in_spk_write_sram_addr  out  9  line address
in_spk_write_sram_we  out  1  write strobe, one cycle per line
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  2  sticky framing error: bit0 = short frame, bit1 = missing s_last; cleared on accepted start

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. s_ready, we, busy, done, err, data, addr, word counter and line counter all go to 0. A partially packed line is discarded. Reset takes priority over every other input.
- States and transitions:
  - IDLE: s_ready=0. start with cfg_num_lines in 1..512 -> LOAD, latch the line count, clear err. start with cfg_num_lines==0 or >512 -> DONE with err=0, no writes.
  - LOAD: s_ready=1. A word is accepted on s_valid&&s_ready.
  - FLUSH: one cycle, s_ready=0; used only for short-frame padding (see below).
  - DONE: single cycle; done=1, busy=0, then -> IDLE.
- Packing: word k of a line (k=0..7, in arrival order) occupies bits [16k+15:16k]. Word 0 is in the LSBs.
- Write timing:
  - The data/addr/we registers update on the clock edge that accepts the 8th word.
  - we is therefore high for exactly one cycle, the cycle after that acceptance.
  - addr = line index (0 for the first line), incremented after each write.
  - s_ready stays high through writes; back-to-back words sustain one line per 8 cycles with no bubbles.
- Completion on the final word of line N-1:
  - The write occurs as above and the state moves to DONE on the same edge.
  - done is therefore coincident with the last we, one cycle after the last word is accepted.
  - If s_last is not asserted on that final word, set err[1]. Further words are not accepted (s_ready=0).
- Short frame (s_last accepted before the final word of line N-1):
  - Set err[0].
  - If the current line holds 1..8 words, zero-fill the unfilled words. Write that line in the cycle after acceptance (this is the FLUSH cycle when the line is incomplete).
  - Then go to DONE.
  - No further lines are written.
- s_last on exactly the final word is normal: err stays 0.
- start while busy: ignored, with no effect on counters or err.
- start and s_valid in the same IDLE cycle: the word is not accepted (s_ready=0).
- Address never wraps: a maximum of 512 lines, with the last address 511.
- Outputs hold their last data/addr when we=0. The SRAM ignores them without we.

Test Plan:
- Reset then start, num_lines=1, words 0x0001..0x0008, s_last on the 8th -> single we, addr=0, data=0x0008_0007_0006_0005_0004_0003_0002_0001, done coincident with we, err=0.
- num_lines=512, continuous valid, words = running index 0..4095, s_last on the last -> 512 we pulses spaced 8 cycles apart, addr 0..511, line 511 bits[15:0]=0x0FF8, done once, err=0.
- num_lines=2, s_last on the 11th word (words 0xA000+i) -> line0 written, line1 = words 8..10 in bits[47:0] with upper bits zero, err=2'b01, done, no third write.
- num_lines=1, 8 words without s_last -> one write, done, err=2'b10, s_ready=0 afterwards; the 9th word is not accepted.
- Random s_valid gaps with num_lines=3; mid-load start pulse and num_lines=0 start -> line data identical to the gap-free run; mid-load start ignored; the zero-length start gives done one cycle after start with no we.
- Assert reset after 5 words of line 1 -> next cycle all outputs 0, state IDLE. A new start with 1 line writes addr 0 with fresh data only.

Source files
------------

// File: rtl/in_spk_loader.sv
// in_spk_loader: host-side writer for the input-spike SRAM.
// Accepts 16-bit spike words over valid/ready and packs eight of them into
// each 128-bit line, word 0 in the LSBs. Lines go to consecutive addresses
// starting at 0. A load ends with a one-cycle done pulse and a sticky
// framing-error code: bit0 = short frame, bit1 = missing s_last.
module in_spk_loader #(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W:0]                  cfg_num_lines,
  input  logic [WORD_W-1:0]                s_data,
  input  logic                             s_valid,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic [WORD_W*WORDS_PER_LINE-1:0] in_spk_write_sram,
  output logic [ADDR_W-1:0]                in_spk_write_sram_addr,
  output logic                             in_spk_write_sram_we,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       err
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int WC_W   = $clog2(WORDS_PER_LINE);

  // Largest legal line count is the full address space (512 lines).
  localparam logic [ADDR_W:0]   MAX_LINES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LINE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS_PER_LINE - 1);
  localparam logic [WC_W-1:0]   WORD_INC  = WC_W'(1);
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [WC_W-1:0]   word_cnt;   // slot the next accepted word lands in
  logic [ADDR_W-1:0] line_cnt;   // address of the line being packed
  logic [ADDR_W-1:0] last_line;  // address of the final line of this load

  logic [WORD_W-1:0] line_buf [WORDS_PER_LINE];
  logic [LINE_W-1:0] packed_line;

  logic accept;
  logic line_full;
  logic final_line;
  logic cfg_legal;

  // s_ready is registered and high only in LOAD, so a word is taken
  // whenever the loader is in LOAD and the host presents one.
  assign accept     = (state == S_LOAD) && s_valid;
  assign line_full  = (word_cnt == LAST_WORD);
  assign final_line = (line_cnt == last_line);
  assign cfg_legal  = (cfg_num_lines != '0) && (cfg_num_lines <= MAX_LINES);

  // Line image as it would look if written now: stored words below the
  // current slot, the incoming word in the current slot, zeros above it.
  // The zero fill covers short-frame padding, and stale words left over
  // from an earlier line or an aborted load never reach the SRAM.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves
    // packed_line unassigned, which would otherwise infer a latch.
    packed_line = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      if (WC_W'(k) < word_cnt) begin
        packed_line[k*WORD_W +: WORD_W] = line_buf[k];
      end else if (WC_W'(k) == word_cnt) begin
        packed_line[k*WORD_W +: WORD_W] = s_data;
      end
    end
  end

  // Capture each accepted word into its slot of the line buffer.
  // NOTE: the buffer deliberately has no reset; packed_line masks every
  // slot at or above word_cnt, so old contents are never visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[word_cnt] <= s_data;
    end
  end

  // Control FSM with registered outputs: start handling, packing counters,
  // SRAM write strobe, completion and sticky error reporting.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // the pre-edge values, independent of statement order.
    if (!reset) begin
      state                  <= S_IDLE;
      s_ready                <= 1'b0;
      in_spk_write_sram      <= '0;
      in_spk_write_sram_addr <= '0;
      in_spk_write_sram_we   <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      err                    <= '0;
      word_cnt               <= '0;
      line_cnt               <= '0;
      last_line              <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      in_spk_write_sram_we <= 1'b0;
      done                 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= '0;
            word_cnt <= '0;
            line_cnt <= '0;
            if (cfg_legal) begin
              state     <= S_LOAD;
              s_ready   <= 1'b1;
              busy      <= 1'b1;
              last_line <= ADDR_W'(cfg_num_lines - ONE_LINE);
            end else begin
              // Zero or oversized request: report completion, write nothing.
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            // A line is written when it fills up, or early (zero-padded)
            // when the host ends the frame partway through it.
            if (line_full || s_last) begin
              in_spk_write_sram_we   <= 1'b1;
              in_spk_write_sram      <= packed_line;
              in_spk_write_sram_addr <= line_cnt;
              line_cnt               <= line_cnt + LINE_INC;
              word_cnt               <= '0;
            end else begin
              word_cnt <= word_cnt + WORD_INC;
            end

            if (line_full && final_line) begin
              // Last word of the last line: done lines up with the write.
              state   <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              s_ready <= 1'b0;
              if (!s_last) begin
                err[1] <= 1'b1;
              end
            end else if (s_last) begin
              // Frame ended before the requested line count was reached.
              err[0]  <= 1'b1;
              s_ready <= 1'b0;
              if (line_full) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_FLUSH;
              end
            end
          end
        end

        S_FLUSH: begin
          // The padded line is being written this cycle; finish next.
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_spk_loader.sv
// Directed bench for in_spk_loader. Expected SRAM writes are pushed to a
// scoreboard queue as stimulus is driven; a negedge monitor pops and compares
// each write strobe. Control outputs are compared inline at each step.
module tb_in_spk_loader;

  logic         clk;
  logic         reset;
  logic         start;
  logic [9:0]   cfg_num_lines;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [127:0] wr_data;
  logic [8:0]   wr_addr;
  logic         wr_we;
  logic         busy;
  logic         done;
  logic [1:0]   err;

  in_spk_loader dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .cfg_num_lines          (cfg_num_lines),
    .s_data                 (s_data),
    .s_valid                (s_valid),
    .s_last                 (s_last),
    .s_ready                (s_ready),
    .in_spk_write_sram      (wr_data),
    .in_spk_write_sram_addr (wr_addr),
    .in_spk_write_sram_we   (wr_we),
    .busy                   (busy),
    .done                   (done),
    .err                    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]   addr;
    logic [127:0] data;
  } wr_t;

  wr_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int prev_we_cyc = 0;
  bit have_prev = 1'b0;
  bit gap_chk = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Eight consecutive 16-bit words first, first+1, ... packed word 0 low.
  function automatic logic [127:0] seq_line(input logic [15:0] first);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = first + 16'(k);
    return l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (wr_we === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        check("we_without_expected_write", 1'b1, 1'b0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
      if (gap_chk && have_prev) check("we_spacing", 128'(cyc - prev_we_cyc), 128'(8));
      prev_we_cyc = cyc;
      have_prev   = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [8:0] a, input logic [127:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [9:0] n);
    start = 1'b1;
    cfg_num_lines = n;
    tick();
    start = 1'b0;
  endtask

  // Present one word and return 1ns after the edge that accepts it.
  task automatic send(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (s_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_ready_timeout", 1'b0, 1'b1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    int t0, we0, done0;

    reset = 1'b0;
    start = 1'b0;
    cfg_num_lines = '0;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_we",      wr_we,   1'b0);
    check("rst_busy",    busy,    1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_err",     err,     2'b00);
    check("rst_addr",    wr_addr, 9'd0);
    check("rst_data",    wr_data, 128'd0);
    reset = 1'b1;
    tick();

    // T1: one line 0x0001..0x0008; a word offered with start is not taken.
    push_wr(9'd0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    pulse_start(10'd1);
    check("t1_busy", busy, 1'b1);
    check("t1_ready", s_ready, 1'b1);
    for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
    check("t1_we", wr_we, 1'b1);
    check("t1_done_with_we", done, 1'b1);
    check("t1_err", err, 2'b00);
    check("t1_busy_end", busy, 1'b0);
    check("t1_ready_end", s_ready, 1'b0);
    tick();
    check("t1_done_pulse", done, 1'b0);
    check("t1_sb_empty", 128'(sb.size()), 128'd0);

    // T2: full 512-line load of a running index, no bubbles.
    for (int l = 0; l < 512; l++) push_wr(9'(l), seq_line(16'(l * 8)));
    we0 = we_cnt;
    done0 = done_cnt;
    have_prev = 1'b0;
    gap_chk = 1'b1;
    pulse_start(10'd512);
    t0 = cyc;
    for (int i = 0; i < 4096; i++) send(16'(i), i == 4095);
    check("t2_cycles", 128'(cyc - t0), 128'd4096);
    check("t2_done", done, 1'b1);
    check("t2_last_addr", wr_addr, 9'd511);
    check("t2_last_word0", wr_data[15:0], 16'h0FF8);
    check("t2_err", err, 2'b00);
    tick();
    gap_chk = 1'b0;
    check("t2_we_count", 128'(we_cnt - we0), 128'd512);
    check("t2_done_count", 128'(done_cnt - done0), 128'd1);
    check("t2_sb_empty", 128'(sb.size()), 128'd0);

    // T3: 2 lines requested, s_last on word 11 -> padded line 1, err[0].
    push_wr(9'd0, seq_line(16'hA000));
    push_wr(9'd1, {80'd0, 16'hA00A, 16'hA009, 16'hA008});
    we0 = we_cnt;
    pulse_start(10'd2);
    for (int i = 0; i < 11; i++) send(16'hA000 + 16'(i), i == 10);
    check("t3_we", wr_we, 1'b1);
    check("t3_no_done_yet", done, 1'b0);
    check("t3_ready", s_ready, 1'b0);
    check("t3_err", err, 2'b01);
    tick();
    check("t3_we_drop", wr_we, 1'b0);
    check("t3_done", done, 1'b1);
    repeat (3) tick();
    check("t3_we_count", 128'(we_cnt - we0), 128'd2);
    check("t3_err_sticky", err, 2'b01);

    // T4: one line without s_last -> err[1]; extra word is refused.
    push_wr(9'd0, seq_line(16'h5000));
    we0 = we_cnt;
    pulse_start(10'd1);
    for (int i = 0; i < 8; i++) send(16'h5000 + 16'(i), 1'b0);
    check("t4_done", done, 1'b1);
    check("t4_we", wr_we, 1'b1);
    check("t4_err", err, 2'b10);
    s_valid = 1'b1;
    s_data  = 16'h9999;
    repeat (3) tick();
    check("t4_ready_after", s_ready, 1'b0);
    s_valid = 1'b0;
    check("t4_we_count", 128'(we_cnt - we0), 128'd1);

    // Zero-length start: done next cycle, err cleared, nothing written.
    we0 = we_cnt;
    pulse_start(10'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_err_cleared", err, 2'b00);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_no_we", 128'(we_cnt - we0), 128'd0);

    // T5: 3 lines with random s_valid gaps and a mid-load start pulse.
    for (int l = 0; l < 3; l++) push_wr(9'(l), seq_line(16'h3000 + 16'(l * 8)));
    we0 = we_cnt;
    pulse_start(10'd3);
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (i == 10) begin
        pulse_start(10'd5);
        check("t5_busy_mid", busy, 1'b1);
        check("t5_err_mid", err, 2'b00);
      end
      send(16'h3000 + 16'(i), i == 23);
    end
    check("t5_done", done, 1'b1);
    check("t5_err", err, 2'b00);
    check("t5_last_addr", wr_addr, 9'd2);
    tick();
    check("t5_we_count", 128'(we_cnt - we0), 128'd3);

    // Oversized request (600 lines) behaves like a zero-length start.
    we0 = we_cnt;
    pulse_start(10'd600);
    check("big_done", done, 1'b1);
    check("big_busy", busy, 1'b0);
    tick();
    check("big_no_we", 128'(we_cnt - we0), 128'd0);

    // T6: reset 5 words into line 1, then a fresh single-line load.
    push_wr(9'd0, seq_line(16'hC000));
    pulse_start(10'd2);
    for (int i = 0; i < 13; i++) send(16'hC000 + 16'(i), 1'b0);
    reset = 1'b0;
    tick();
    check("t6_rst_ready", s_ready, 1'b0);
    check("t6_rst_we",    wr_we,   1'b0);
    check("t6_rst_busy",  busy,    1'b0);
    check("t6_rst_done",  done,    1'b0);
    check("t6_rst_err",   err,     2'b00);
    check("t6_rst_addr",  wr_addr, 9'd0);
    check("t6_rst_data",  wr_data, 128'd0);
    reset = 1'b1;
    tick();
    push_wr(9'd0, seq_line(16'hB000));
    we0 = we_cnt;
    pulse_start(10'd1);
    for (int i = 0; i < 8; i++) send(16'hB000 + 16'(i), i == 7);
    check("t6_done", done, 1'b1);
    check("t6_err", err, 2'b00);
    repeat (2) tick();
    check("t6_we_count", 128'(we_cnt - we0), 128'd1);
    check("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
